trace_mem_ctrl: RTL and testbench

TRACE_MEM_CTRL -- requirements
Module: trace_mem_ctrl

---
 rtl/trace_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_trace_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : trace_mem_ctrl
// Purpose : Trace capture ring buffer with post-trigger delay, or host FIFO
// Revision: 1.0
// ============================================================================
module trace_mem_ctrl #(
    parameter  int TRB_WIDTH = 32,
    parameter  int TRB_DEPTH = 64,
    localparam int AW        = $clog2(TRB_DEPTH)
) (
    input  logic                 FPGA_CLK_I,
    input  logic                 RST_I,
    input  logic                 EN_I,
    input  logic                 MODE_I,
    input  logic [AW-1:0]        TRG_DELAY_I,
    input  logic                 TRG_EVENT_I,
    input  logic                 STORE_I,
    input  logic [TRB_WIDTH-1:0] DATA_I,
    input  logic                 LOAD_I,
    output logic                 LOAD_O,
    output logic [TRB_WIDTH-1:0] DATA_O,
    output logic                 TRG_EVENT_O,
    input  logic                 HOST_WE_I,
    input  logic [TRB_WIDTH-1:0] HOST_WDATA_I,
    input  logic                 HOST_RE_I,
    output logic                 HOST_RVALID_O,
    output logic [TRB_WIDTH-1:0] HOST_RDATA_O,
    output logic [AW-1:0]        EVENT_ADDR_O,
    output logic                 DONE_O,
    output logic                 FULL_O,
    output logic                 EMPTY_O,
    output logic                 OVERFLOW_O
);

    localparam logic [AW:0] c_full_cnt = (AW+1)'(TRB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DELAY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [TRB_WIDTH-1:0] r_mem [TRB_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr, r_cnt, r_event_addr;
    logic [AW:0]          r_count;
    logic                 r_pend, r_ovf, r_mode_q, r_done, r_trg_o, r_load_o, r_hrvalid;
    logic [TRB_WIDTH-1:0] r_data_o, r_hrdata;

    logic                 w_mode_chg, w_run_trace, w_stream, w_full, w_empty;
    logic                 w_capture, w_trig, w_push, w_pop, w_tload, w_hread, w_we;
    logic                 w_arm, w_enter_done;
    logic [AW-1:0]        w_wr_ptr_nxt;
    logic [TRB_WIDTH-1:0] w_wdata;

    // A mode change costs one dead cycle in which everything is flushed
    assign w_mode_chg   = (MODE_I != r_mode_q);
    assign w_run_trace  = EN_I && !MODE_I && !w_mode_chg;
    assign w_stream     = EN_I &&  MODE_I && !w_mode_chg;
    assign w_full       = (r_count == c_full_cnt);
    assign w_empty      = (r_count == '0);
    assign w_capture    = w_run_trace && STORE_I && (r_state == S_ARMED || r_state == S_DELAY);
    assign w_trig       = w_run_trace && TRG_EVENT_I && (r_state == S_ARMED);
    assign w_push       = w_stream && HOST_WE_I && !w_full;
    assign w_pop        = w_stream && !w_empty && (LOAD_I || r_pend);
    assign w_tload      = !MODE_I && !w_mode_chg && LOAD_I;
    assign w_hread      = w_run_trace && (r_state == S_DONE) && HOST_RE_I;
    assign w_we         = w_capture || w_push;
    assign w_wdata      = MODE_I ? HOST_WDATA_I : DATA_I;
    assign w_wr_ptr_nxt = r_wr_ptr + AW'(w_we);
    assign w_arm        = (r_state == S_IDLE) && (w_state_nxt == S_ARMED);
    assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_run_trace) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_ARMED;
                S_ARMED: if (TRG_EVENT_I) w_state_nxt = (TRG_DELAY_I == '0) ? S_DONE : S_DELAY;
                S_DELAY: if (STORE_I && r_cnt == AW'(1)) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            r_mode_q     <= MODE_I;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_count      <= '0;
            r_pend       <= 1'b0;
            r_ovf        <= 1'b0;
            r_done       <= 1'b0;
            r_trg_o      <= 1'b0;
            r_event_addr <= '0;
            r_load_o     <= 1'b0;
            r_hrvalid    <= 1'b0;
            r_data_o     <= '0;
            r_hrdata     <= '0;
        end else begin
            r_mode_q  <= MODE_I;
            r_load_o  <= w_tload || w_pop;
            r_hrvalid <= w_hread;
            r_done    <= (w_state_nxt == S_DONE);

            // Read-before-write: sees the old word even if it is overwritten now
            if (w_tload) begin
                r_data_o <= r_mem[r_wr_ptr];
            end else if (w_pop) begin
                r_data_o <= r_mem[r_rd_ptr];
            end
            if (w_hread) begin
                r_hrdata <= r_mem[r_rd_ptr];
            end

            if (w_mode_chg) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
                r_count  <= '0;
                r_pend   <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_arm) begin
                    r_wr_ptr <= '0;
                    r_trg_o  <= 1'b0;
                end else if (w_we) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end

                // Oldest word sits right after the last one written
                if (w_enter_done) begin
                    r_rd_ptr <= w_wr_ptr_nxt;
                    r_trg_o  <= 1'b1;
                end else if (w_hread || w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end

                if (w_trig) begin
                    r_event_addr <= r_wr_ptr;
                    r_cnt        <= TRG_DELAY_I;
                end else if (w_capture && r_state == S_DELAY) begin
                    r_cnt <= r_cnt - AW'(1);
                end

                if (w_push && !w_pop) begin
                    r_count <= r_count + (AW+1)'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - (AW+1)'(1);
                end

                if (w_pop) begin
                    r_pend <= 1'b0;
                end else if (w_stream && LOAD_I && w_empty) begin
                    r_pend <= 1'b1;
                end

                if (w_stream && HOST_WE_I && w_full) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign LOAD_O        = r_load_o;
    assign DATA_O        = r_data_o;
    assign TRG_EVENT_O   = r_trg_o;
    assign HOST_RVALID_O = r_hrvalid;
    assign HOST_RDATA_O  = r_hrdata;
    assign EVENT_ADDR_O  = r_event_addr;
    assign DONE_O        = r_done;
    assign FULL_O        = w_full;
    assign EMPTY_O       = w_empty;
    assign OVERFLOW_O    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_trace_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_mem_ctrl
// Purpose : Directed self-checking bench for trace_mem_ctrl (64 x 32)
// Revision: 1.0
// ============================================================================
module tb_trace_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, mode = 1'b0;
    logic [5:0]  trg_delay = '0;
    logic        trg_event = 1'b0, store = 1'b0, load = 1'b0;
    logic [31:0] data_in = '0;
    logic        load_o;
    logic [31:0] data_o;
    logic        trg_o;
    logic        host_we = 1'b0, host_re = 1'b0;
    logic [31:0] host_wdata = '0;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [5:0]  event_addr;
    logic        done, full, empty, ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trace_mem_ctrl #(.TRB_WIDTH(32), .TRB_DEPTH(64)) dut (
        .FPGA_CLK_I   (clk),
        .RST_I        (rst),
        .EN_I         (en),
        .MODE_I       (mode),
        .TRG_DELAY_I  (trg_delay),
        .TRG_EVENT_I  (trg_event),
        .STORE_I      (store),
        .DATA_I       (data_in),
        .LOAD_I       (load),
        .LOAD_O       (load_o),
        .DATA_O       (data_o),
        .TRG_EVENT_O  (trg_o),
        .HOST_WE_I    (host_we),
        .HOST_WDATA_I (host_wdata),
        .HOST_RE_I    (host_re),
        .HOST_RVALID_O(host_rvalid),
        .HOST_RDATA_O (host_rdata),
        .EVENT_ADDR_O (event_addr),
        .DONE_O       (done),
        .FULL_O       (full),
        .EMPTY_O      (empty),
        .OVERFLOW_O   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          pulses;
        logic [31:0] last_data;
        int          exp_addr;
        logic        t_load [10];
        logic        t_we   [10];
        logic [31:0] t_wd   [10];

        // ---------------- reset ----------------
        tick; tick;
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", ovf, 0);
        check("rst_load_o", load_o, 0);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_trg_o", trg_o, 0);
        check("rst_evaddr", event_addr, 0);
        check("rst_data_o", data_o, 0);
        rst = 1'b0;

        // ---------------- prefill, delay 0 with store in trigger cycle ----------------
        en = 1'b1; mode = 1'b0; trg_delay = 6'd0;
        tick;
        for (int i = 0; i < 64; i++) begin
            store = 1'b1; data_in = 32'h100 + i; trg_event = (i == 63);
            tick;
            if (i == 62) check("d0_done_before", done, 0);
        end
        check("d0_done", done, 1);
        check("d0_trg_o", trg_o, 1);
        check("d0_evaddr", event_addr, 63);
        data_in = 32'hDEAD; trg_event = 1'b0;
        tick;
        store = 1'b0; load = 1'b1;
        tick;
        check("d0_tload_v", load_o, 1);
        check("d0_tload_d", data_o, 32'h100);
        load = 1'b0; host_re = 1'b1;
        tick;
        check("d0_rvalid", host_rvalid, 1);
        check("d0_rdata", host_rdata, 32'h100);
        check("d0_load_pulse", load_o, 0);
        host_re = 1'b0;
        tick;
        check("d0_rvalid_pulse", host_rvalid, 0);
        check("d0_rdata_hold", host_rdata, 32'h100);
        en = 1'b0;
        tick;
        check("idle_done", done, 0);

        // ---------------- 100 stores, trigger at 40, delay 10 ----------------
        en = 1'b1; trg_delay = 6'd10;
        tick;
        for (int i = 0; i < 100; i++) begin
            store = 1'b1; data_in = i; trg_event = (i >= 40); load = (i == 5);
            tick;
            if (i == 5) begin
                check("rbw_load_v", load_o, 1);
                check("rbw_load_d", data_o, 32'h105);
            end
            if (i == 49) begin
                check("cap_done_49", done, 0);
                check("cap_trg_49", trg_o, 0);
            end
            if (i == 50) begin
                check("cap_done_50", done, 1);
                check("cap_trg_50", trg_o, 1);
                check("cap_evaddr", event_addr, 40);
            end
        end
        store = 1'b0; trg_event = 1'b0; load = 1'b0;
        host_re = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick;
            exp_addr = (51 + k) % 64;
            check("readout_v", host_rvalid, 1);
            check("readout_d", host_rdata, (exp_addr <= 50) ? exp_addr : 32'h100 + exp_addr);
        end
        host_re = 1'b0;
        tick;
        check("readout_end", host_rvalid, 0);

        // ---------------- reset in DELAY ----------------
        en = 1'b0;
        tick;
        en = 1'b1; trg_delay = 6'd5;
        tick;
        for (int i = 0; i < 4; i++) begin
            store = 1'b1; data_in = 32'h77; trg_event = (i == 2);
            tick;
        end
        store = 1'b0; trg_event = 1'b0;
        check("dly_evaddr", event_addr, 2);
        check("dly_done", done, 0);
        rst = 1'b1;
        tick;
        check("dlyrst_done", done, 0);
        check("dlyrst_evaddr", event_addr, 0);
        check("dlyrst_empty", empty, 1);
        check("dlyrst_data_o", data_o, 0);
        check("dlyrst_trg_o", trg_o, 0);
        rst = 1'b0;

        // ---------------- stream: fill, overflow, drain ----------------
        mode = 1'b1;
        tick;
        for (int i = 0; i < 64; i++) begin
            host_we = 1'b1; host_wdata = 32'h5000 + i;
            tick;
            if (i == 62) check("fifo_full_63", full, 0);
        end
        check("fifo_full_64", full, 1);
        check("fifo_ovf_pre", ovf, 0);
        host_wdata = 32'hBAD;
        tick;
        check("fifo_ovf", ovf, 1);
        host_we = 1'b0; load = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick;
            check("fifo_pop_v", load_o, 1);
            check("fifo_pop_d", data_o, 32'h5000 + k);
            if (k == 0) check("fifo_notfull", full, 0);
        end
        load = 1'b0;
        check("fifo_empty", empty, 1);
        check("fifo_ovf_sticky", ovf, 1);
        tick;
        check("fifo_load_pulse", load_o, 0);

        // ---------------- pending read on empty FIFO ----------------
        t_load = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        t_we   = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        t_wd   = '{0, 0, 0, 32'hA5, 0, 0, 32'h5A, 0, 0, 0};
        pulses = 0; last_data = '0;
        for (int c = 0; c < 10; c++) begin
            load = t_load[c]; host_we = t_we[c]; host_wdata = t_wd[c];
            tick;
            if (load_o) begin
                pulses++;
                last_data = data_o;
            end
        end
        load = 1'b0; host_we = 1'b0;
        check("pend_pulses", pulses, 1);
        check("pend_data", last_data, 32'hA5);
        check("pend_left", empty, 0);

        // ---------------- push+pop at count 5 ----------------
        for (int i = 0; i < 4; i++) begin
            host_we = 1'b1; host_wdata = 32'h61 + i;
            tick;
        end
        host_wdata = 32'h65; load = 1'b1;
        tick;
        check("pp_pop_v", load_o, 1);
        check("pp_pop_d", data_o, 32'h5A);
        host_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("pp_drain_d", data_o, 32'h61 + k);
            if (k == 3) check("pp_empty_4", empty, 0);
            if (k == 4) check("pp_empty_5", empty, 1);
        end
        load = 1'b0;

        // ---------------- mode change flush ----------------
        host_we = 1'b1; host_wdata = 32'h11;
        tick; tick;
        host_we = 1'b0;
        check("flush_pre_empty", empty, 0);
        mode = 1'b0;
        tick;
        check("flush_empty", empty, 1);
        check("flush_ovf", ovf, 0);
        en = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
